long_sum_serializer: RTL and testbench



---
 rtl/long_sum_serializer.sv | 112 +++++++++++
 tb/tb_long_sum_serializer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/long_sum_serializer.sv
// Captures SIZE-bit sums and streams them LS word first as WORD-bit beats,
// with a one-entry pending buffer and a sticky overflow flag for dropped sums.
module long_sum_serializer #(
    parameter int SIZE = 1024,
    parameter int WORD = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] sum,
    input  logic            sum_valid,
    output logic            in_ready,
    output logic [WORD-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last,
    output logic            overflow,
    input  logic            overflow_clr
);

    localparam int NUM_WORDS = (SIZE + WORD - 1) / WORD;
    localparam int PAD       = NUM_WORDS * WORD;
    localparam int CW        = $clog2(NUM_WORDS) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NUM_WORDS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state, state_nxt;
    logic [PAD-1:0]  sr, sr_nxt;
    logic [PAD-1:0]  pend, pend_nxt;
    logic            pend_valid, pend_valid_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            overflow_nxt;
    logic [PAD-1:0]  sum_ext;
    logic            busy, at_last, done, beat;

    always_comb begin
        sum_ext            = '0;
        sum_ext[SIZE-1:0]  = sum;
    end

    assign busy     = (state == SEND);
    assign at_last  = busy && (cnt == LAST_CNT);
    assign done     = at_last && out_ready;
    assign beat     = busy && out_ready && !at_last;

    assign out_valid = busy;
    assign out_data  = sr[WORD-1:0];
    assign out_last  = at_last;
    assign in_ready  = !pend_valid;

    always_comb begin
        state_nxt      = state;
        sr_nxt         = sr;
        pend_nxt       = pend;
        pend_valid_nxt = pend_valid;
        cnt_nxt        = cnt;
        overflow_nxt   = overflow_clr ? 1'b0 : overflow;

        if (beat) begin
            sr_nxt  = sr >> WORD;
            cnt_nxt = cnt + CW'(1);
        end

        if (!busy) begin
            if (sum_valid) begin
                sr_nxt    = sum_ext;
                cnt_nxt   = '0;
                state_nxt = SEND;
            end
        end else if (done) begin
            // On the last beat the pending entry frees up, so a same-cycle arrival never overflows.
            if (pend_valid) begin
                sr_nxt         = pend;
                cnt_nxt        = '0;
                pend_valid_nxt = sum_valid;
                if (sum_valid)
                    pend_nxt = sum_ext;
            end else if (sum_valid) begin
                sr_nxt  = sum_ext;
                cnt_nxt = '0;
            end else begin
                state_nxt = IDLE;
            end
        end else if (sum_valid) begin
            if (!pend_valid) begin
                pend_nxt       = sum_ext;
                pend_valid_nxt = 1'b1;
            end else begin
                overflow_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sr         <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            cnt        <= '0;
            overflow   <= 1'b0;
        end else begin
            state      <= state_nxt;
            sr         <= sr_nxt;
            pend       <= pend_nxt;
            pend_valid <= pend_valid_nxt;
            cnt        <= cnt_nxt;
            overflow   <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_long_sum_serializer.sv
// Randomized self-checking bench for long_sum_serializer (SIZE=130, WORD=32)
// against a queue-based model of sums in flight.
module tb_long_sum_serializer;

    localparam int SIZE = 130;
    localparam int WORD = 32;
    localparam int NW   = 5;

    logic             clk;
    logic             rst_n;
    logic [SIZE-1:0]  sum;
    logic             sum_valid;
    logic             in_ready;
    logic [WORD-1:0]  out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             overflow;
    logic             overflow_clr;

    int errors = 0;
    int checks = 0;

    // Model: queue of accepted sums (head is being sent), head beat index, sticky flag.
    logic [159:0] q[$];
    int           bidx;
    logic         m_ovf;
    int           m_drops;

    long_sum_serializer #(.SIZE(SIZE), .WORD(WORD)) dut (
        .clk(clk), .rst_n(rst_n), .sum(sum), .sum_valid(sum_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [SIZE-1:0] s, input int i);
        logic [159:0] p;
        p = {30'b0, s};
        return p[32*i +: 32];
    endfunction

    function automatic logic [SIZE-1:0] rand_sum();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[SIZE-1:0];
    endfunction

    function automatic logic [31:0] m_data();
        return q[0][32*bidx +: 32];
    endfunction

    task automatic model_reset();
        q.delete();
        bidx    = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, return 1 ns after it.
    task automatic tick(input logic sv, input logic [SIZE-1:0] s, input logic rdy, input logic clr);
        int   occ;
        logic fin, drop;
        sum_valid    = sv;
        sum          = s;
        out_ready    = rdy;
        overflow_clr = clr;
        @(posedge clk);
        fin  = (q.size() > 0) && (bidx == NW - 1) && rdy;
        occ  = q.size() - (fin ? 1 : 0);
        drop = sv && (occ >= 2);
        if (drop) begin
            m_ovf = 1'b1;
            m_drops++;
        end else if (clr) begin
            m_ovf = 1'b0;
        end
        if (q.size() > 0 && rdy) begin
            if (bidx == NW - 1) begin
                void'(q.pop_front());
                bidx = 0;
            end else begin
                bidx++;
            end
        end
        if (sv && !drop)
            q.push_back({30'b0, s});
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sum = '0; sum_valid = 0; out_ready = 0; overflow_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%b want=0", out_last); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        logic [SIZE-1:0] s;
        logic [31:0] ew[5];
        s = {2'b11, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210};
        ew[0] = 32'h76543210; ew[1] = 32'hFEDCBA98; ew[2] = 32'h89ABCDEF;
        ew[3] = 32'h01234567; ew[4] = 32'h00000003;
        tick(1'b1, s, 1'b1, 1'b0);
        for (int i = 0; i < NW; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid beat=%0d got=%b want=1", i, out_valid); end
            checks++; if (out_data !== ew[i]) begin errors++; $display("FAIL stream_data beat=%0d got=%h want=%h", i, out_data, ew[i]); end
            checks++; if (out_last !== (i == NW - 1)) begin errors++; $display("FAIL stream_last beat=%0d got=%b want=%b", i, out_last, (i == NW - 1)); end
            tick(1'b0, '0, 1'b1, 1'b0);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_idle got=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [SIZE-1:0] s[3];
        logic [31:0] exp_w;
        for (int i = 0; i < 3; i++) s[i] = rand_sum();
        for (int k = 0; k < 15; k++) begin
            if (k == 0)      tick(1'b1, s[0], 1'b1, 1'b0);
            else if (k == 1) tick(1'b1, s[1], 1'b1, 1'b0);
            else if (k == 5) tick(1'b1, s[2], 1'b1, 1'b0);
            else             tick(1'b0, '0, 1'b1, 1'b0);
            exp_w = word_of(s[k / 5], k % 5);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid cyc=%0d got=%b want=1", k, out_valid); end
            checks++; if (out_data !== exp_w) begin errors++; $display("FAIL b2b_data cyc=%0d got=%h want=%h", k, out_data, exp_w); end
            checks++; if (in_ready !== (q.size() < 2)) begin errors++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=%b", k, in_ready, (q.size() < 2)); end
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow cyc=%0d got=%b want=0", k, overflow); end
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got=%b want=0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [SIZE-1:0] a, b, c;
        logic [31:0] got[$];
        logic [31:0] exp_w;
        a = rand_sum(); b = rand_sum(); c = rand_sum();
        tick(1'b1, a, 1'b0, 1'b0);
        tick(1'b1, b, 1'b0, 1'b0);
        tick(1'b1, c, 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b want=1", overflow); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ovf_in_ready got=%b want=0", in_ready); end
        checks++; if (out_data !== word_of(a, 0)) begin errors++; $display("FAIL ovf_stall_data got=%h want=%h", out_data, word_of(a, 0)); end
        for (int k = 0; k < 20; k++) begin
            if (out_valid === 1'b1) got.push_back(out_data);
            tick(1'b0, '0, 1'b1, 1'b0);
        end
        checks++; if (got.size() != 10) begin errors++; $display("FAIL ovf_beat_count got=%0d want=10", got.size()); end
        for (int i = 0; i < got.size() && i < 10; i++) begin
            exp_w = word_of((i < 5) ? a : b, i % 5);
            checks++; if (got[i] !== exp_w) begin errors++; $display("FAIL ovf_order beat=%0d got=%h want=%h", i, got[i], exp_w); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
        tick(1'b0, '0, 1'b1, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b want=0", overflow); end
    endtask

    task automatic test_set_clr();
        tick(1'b1, rand_sum(), 1'b0, 1'b0);
        tick(1'b1, rand_sum(), 1'b0, 1'b0);
        tick(1'b1, rand_sum(), 1'b0, 1'b1);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL setclr_priority got=%b want=1", overflow); end
        tick(1'b0, '0, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL setclr_clear got=%b want=0", overflow); end
        repeat (12) tick(1'b0, '0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL setclr_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic        rdy, pv, pr;
        logic [31:0] pd;
        int          beats, drops0;
        beats = 0; drops0 = m_drops;
        pv = 1'b0; pr = 1'b1; pd = '0;
        for (int k = 0; k < 200; k++) begin
            rdy = ($urandom % 3) != 0;
            if (out_valid === 1'b1 && rdy) beats++;
            pv = out_valid; pd = out_data; pr = rdy;
            tick((k == 0) || (k == 4) || (k == 25), rand_sum(), rdy, 1'b0);
            checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b want=%b", k, out_valid, (q.size() > 0)); end
            if (q.size() > 0) begin
                checks++; if (out_data !== m_data()) begin errors++; $display("FAIL bp_data cyc=%0d got=%h want=%h", k, out_data, m_data()); end
                checks++; if (out_last !== (bidx == NW - 1)) begin errors++; $display("FAIL bp_last cyc=%0d got=%b want=%b", k, out_last, (bidx == NW - 1)); end
            end
            if (pv === 1'b1 && !pr) begin
                checks++; if (out_valid !== 1'b1 || out_data !== pd) begin errors++; $display("FAIL bp_stable cyc=%0d got=%b/%h want=1/%h", k, out_valid, out_data, pd); end
            end
            checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL bp_overflow cyc=%0d got=%b want=%b", k, overflow, m_ovf); end
        end
        checks++; if (beats != 5 * (3 - (m_drops - drops0))) begin errors++; $display("FAIL bp_beat_count got=%0d want=%0d", beats, 5 * (3 - (m_drops - drops0))); end
        tick(1'b0, '0, 1'b1, 1'b1);
    endtask

    task automatic test_reset_mid();
        logic [SIZE-1:0] d;
        d = rand_sum();
        tick(1'b1, rand_sum(), 1'b0, 1'b0);
        tick(1'b1, rand_sum(), 1'b0, 1'b0);
        tick(1'b1, rand_sum(), 1'b0, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        sum_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b want=1", in_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow got=%b want=0", overflow); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_hold got=%b want=0", out_valid); end
        rst_n = 1'b1;
        tick(1'b1, d, 1'b1, 1'b0);
        for (int i = 0; i < NW; i++) begin
            checks++; if (out_data !== word_of(d, i) || out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_new beat=%0d got=%b/%h want=1/%h", i, out_valid, out_data, word_of(d, i)); end
            checks++; if (out_last !== (i == NW - 1)) begin errors++; $display("FAIL rstmid_last beat=%0d got=%b want=%b", i, out_last, (i == NW - 1)); end
            tick(1'b0, '0, 1'b1, 1'b0);
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_idle got=%b want=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_overflow();
        test_set_clr();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
